// File: rtl/video_in_pack.sv
`default_nettype none
// ============================================================================
// Module   : video_in_pack
// Purpose  : Captures a frame_valid/line_valid qualified pixel stream and
//            packs P_PACK consecutive pixels into one word for a downstream
//            FIFO. The first pixel of each group lands in the MSBs. Line and
//            frame lengths are checked against P_WIDTH/P_HEIGHT. Words that
//            arrive while the FIFO is full are dropped and flagged.
// Ports    : clk, RST (sync, active-high)
//            frame_valid, line_valid, pixel_in  - video input
//            fifo_full                           - downstream backpressure
//            w_e, data_out, sof, eol             - packed word output
//            err_line, err_frame, err_ovf        - single-cycle error pulses
// Revision : 1.0 - initial release
// ============================================================================
module video_in_pack #(
   parameter int P_WIDTH  = 640,
   parameter int P_HEIGHT = 480,
   parameter int P_PIX_W  = 8,
   parameter int P_PACK   = 4
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic                       frame_valid,
   input  logic                       line_valid,
   input  logic [P_PIX_W-1:0]         pixel_in,
   input  logic                       fifo_full,
   output logic                       w_e,
   output logic [P_PIX_W*P_PACK-1:0]  data_out,
   output logic                       sof,
   output logic                       eol,
   output logic                       err_line,
   output logic                       err_frame,
   output logic                       err_ovf
);

   localparam int PIX_CW  = $clog2(P_WIDTH + 1);
   localparam int LINE_CW = $clog2(P_HEIGHT + 1);
   localparam int SLOT_W  = (P_PACK > 1) ? $clog2(P_PACK) : 1;
   localparam int WORD_W  = P_PIX_W * P_PACK;

   localparam logic [PIX_CW-1:0]  C_WIDTH      = PIX_CW'(P_WIDTH);
   localparam logic [PIX_CW-1:0]  C_LAST_PIX   = PIX_CW'(P_WIDTH - 1);
   localparam logic [PIX_CW-1:0]  C_FIRST_WORD = PIX_CW'(P_PACK - 1);
   localparam logic [LINE_CW-1:0] C_HEIGHT     = LINE_CW'(P_HEIGHT);
   localparam logic [LINE_CW-1:0] C_LAST_LINE  = LINE_CW'(P_HEIGHT - 1);
   localparam logic [SLOT_W-1:0]  C_LAST_SLOT  = SLOT_W'(P_PACK - 1);

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2,
      HBLANK = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PIX_CW-1:0]    pix_cnt_q, pix_cnt_d;
   logic                 pix_ovf_q, pix_ovf_d;     // line ran past P_WIDTH
   logic [LINE_CW-1:0]   line_cnt_q, line_cnt_d;
   logic                 line_ovf_q, line_ovf_d;   // frame ran past P_HEIGHT
   logic [SLOT_W-1:0]    slot_q, slot_d;           // position inside the group
   logic [WORD_W-1:0]    data_out_q, data_out_d;
   logic                 w_e_q, w_e_d;
   logic                 sof_q, sof_d;
   logic                 eol_q, eol_d;
   logic                 err_line_q, err_line_d;
   logic                 err_frame_q, err_frame_d;
   logic                 err_ovf_q, err_ovf_d;

   logic                 w_pix;
   logic                 w_accept;

   // A pixel is sampled in HBLANK too: that cycle is the HBLANK->ACTIVE
   // transition and carries pixel 0 of the line.
   assign w_pix    = frame_valid & line_valid &
                     ((state_q == ACTIVE) | (state_q == HBLANK));
   assign w_accept = w_pix & (pix_cnt_q < C_WIDTH) & (line_cnt_q < C_HEIGHT);

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      pix_ovf_d   = pix_ovf_q;
      line_cnt_d  = line_cnt_q;
      line_ovf_d  = line_ovf_q;
      slot_d      = slot_q;
      data_out_d  = data_out_q;
      w_e_d       = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      err_line_d  = 1'b0;
      err_frame_d = 1'b0;
      err_ovf_d   = 1'b0;

      case (state_q)
         SYNC: begin
            if (!frame_valid) state_d = VBLANK;
         end
         VBLANK: begin
            line_cnt_d = '0;
            line_ovf_d = 1'b0;
            pix_cnt_d  = '0;
            pix_ovf_d  = 1'b0;
            slot_d     = '0;
            if (frame_valid) state_d = HBLANK;
         end
         HBLANK: begin
            if (!frame_valid) begin
               state_d     = VBLANK;
               err_frame_d = line_ovf_q | (line_cnt_q != C_HEIGHT);
               line_cnt_d  = '0;
               line_ovf_d  = 1'b0;
            end else if (line_valid) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!(frame_valid && line_valid)) begin
               // Line check first; a simultaneous frame end then counts
               // this line as completed, so both pulses may coincide.
               err_line_d = pix_ovf_q | (pix_cnt_q != C_WIDTH);
               pix_cnt_d  = '0;
               pix_ovf_d  = 1'b0;
               slot_d     = '0;
               if (frame_valid) begin
                  state_d = HBLANK;
                  if (line_cnt_q == C_HEIGHT) line_ovf_d = 1'b1;
                  else                        line_cnt_d = line_cnt_q + LINE_CW'(1);
               end else begin
                  state_d     = VBLANK;
                  err_frame_d = line_ovf_q | (line_cnt_q != C_LAST_LINE);
                  line_cnt_d  = '0;
                  line_ovf_d  = 1'b0;
               end
            end
         end
         default: state_d = SYNC;
      endcase

      if (w_pix) begin
         if (pix_cnt_q == C_WIDTH) pix_ovf_d = 1'b1;
         else                      pix_cnt_d = pix_cnt_q + PIX_CW'(1);
      end

      if (w_accept) begin
         for (int i = 0; i < P_PACK; i++) begin
            if (slot_q == SLOT_W'(i))
               data_out_d[(P_PACK-1-i)*P_PIX_W +: P_PIX_W] = pixel_in;
         end
         if (slot_q == C_LAST_SLOT) begin
            slot_d = '0;
            // Backpressure is judged on the edge that completes the word;
            // a dropped word is never retried.
            if (fifo_full) begin
               err_ovf_d = 1'b1;
            end else begin
               w_e_d = 1'b1;
               sof_d = (line_cnt_q == '0) && (pix_cnt_q == C_FIRST_WORD);
               eol_d = (pix_cnt_q == C_LAST_PIX);
            end
         end else begin
            slot_d = slot_q + SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= SYNC;
         pix_cnt_q   <= '0;
         pix_ovf_q   <= 1'b0;
         line_cnt_q  <= '0;
         line_ovf_q  <= 1'b0;
         slot_q      <= '0;
         data_out_q  <= '0;
         w_e_q       <= 1'b0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         pix_ovf_q   <= pix_ovf_d;
         line_cnt_q  <= line_cnt_d;
         line_ovf_q  <= line_ovf_d;
         slot_q      <= slot_d;
         data_out_q  <= data_out_d;
         w_e_q       <= w_e_d;
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         err_line_q  <= err_line_d;
         err_frame_q <= err_frame_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign w_e       = w_e_q;
   assign data_out  = data_out_q;
   assign sof       = sof_q;
   assign eol       = eol_q;
   assign err_line  = err_line_q;
   assign err_frame = err_frame_q;
   assign err_ovf   = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_video_in_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_in_pack
// Purpose  : Self-checking bench for video_in_pack (8x2 frame, 8-bit pixels,
//            4 pixels per word). Frames are described line by line; the
//            expected outputs for every cycle are derived from the line
//            geometry while the stimulus is generated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_in_pack;

   localparam int W  = 8;
   localparam int H  = 2;
   localparam int PW = 8;
   localparam int PK = 4;

   logic          clk = 1'b0;
   logic          RST;
   logic          frame_valid;
   logic          line_valid;
   logic [PW-1:0] pixel_in;
   logic          fifo_full;
   logic          w_e;
   logic [PW*PK-1:0] data_out;
   logic          sof;
   logic          eol;
   logic          err_line;
   logic          err_frame;
   logic          err_ovf;

   int checks = 0;
   int errors = 0;

   video_in_pack #(
      .P_WIDTH (W),
      .P_HEIGHT(H),
      .P_PIX_W (PW),
      .P_PACK  (PK)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .frame_valid(frame_valid),
      .line_valid (line_valid),
      .pixel_in   (pixel_in),
      .fifo_full  (fifo_full),
      .w_e        (w_e),
      .data_out   (data_out),
      .sof        (sof),
      .eol        (eol),
      .err_line   (err_line),
      .err_frame  (err_frame),
      .err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, fv, lv, ff;
      logic [7:0] pix;
   } stim_t;

   typedef struct {
      logic        we, sof, eol, el, ef, eo, chk_data;
      logic [31:0] data;
   } exp_t;

   stim_t sq[$];
   exp_t  eq[$];

   function automatic exp_t no_exp();
      exp_t e;
      e.we = 0; e.sof = 0; e.eol = 0; e.el = 0; e.ef = 0; e.eo = 0;
      e.chk_data = 0; e.data = '0;
      return e;
   endfunction

   task automatic push(input logic rst, input logic fv, input logic lv,
                       input logic ff, input logic [7:0] pix, input exp_t e);
      stim_t s;
      s.rst = rst; s.fv = fv; s.lv = lv; s.ff = ff; s.pix = pix;
      sq.push_back(s);
      eq.push_back(e);
   endtask

   task automatic idle(input int n, input logic fv);
      for (int i = 0; i < n; i++) push(1'b0, fv, 1'b0, 1'b0, 8'h00, no_exp());
   endtask

   // One line of len pixels followed by its line_valid falling cycle.
   // base < 0 selects random pixels, otherwise pixel p = base + p + 1.
   // blk: index of the word whose completion sees fifo_full (-1 = none).
   task automatic do_line(input int l, input int len, input int base,
                          input int blk, input logic simul, input int nl);
      logic [7:0] px[$];
      logic [7:0] pv;
      logic [31:0] word;
      logic ff;
      exp_t e;
      for (int p = 0; p <= len; p++) begin
         ff = (p / PK == blk) || (p > 0 && (p - 1) / PK == blk);
         e  = no_exp();
         if (p < len) begin
            pv = (base < 0) ? 8'($urandom) : 8'(base + p + 1);
            px.push_back(pv);
            if (l < H && p < W && p % PK == PK - 1) begin
               word = '0;
               for (int j = 0; j < PK; j++) word = (word << PW) | 32'(px[p-PK+1+j]);
               if (p / PK == blk) begin
                  e.eo = 1'b1;
               end else begin
                  e.we = 1'b1; e.chk_data = 1'b1; e.data = word;
                  e.sof = (l == 0 && p == PK - 1);
                  e.eol = (p == W - 1);
               end
            end
            push(1'b0, 1'b1, 1'b1, ff, pv, e);
         end else begin
            e.el = (len != W);
            if (simul) e.ef = (nl != H);
            push(1'b0, !simul, 1'b0, ff, 8'h00, e);
         end
      end
   endtask

   task automatic frame(input int nl, input int lens[4], input int bases[4],
                        input int blk_line, input int blk_word, input logic simul);
      exp_t e;
      idle(2, 1'b0);
      idle(2, 1'b1);
      for (int l = 0; l < nl; l++) begin
         do_line(l, lens[l], bases[l], (l == blk_line) ? blk_word : -1,
                 simul && (l == nl - 1), nl);
         if (!(simul && l == nl - 1)) idle($urandom_range(1, 3), 1'b1);
      end
      if (!simul) begin
         e = no_exp();
         e.ef = (nl != H);
         push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e);
      end
      idle(1, 1'b0);
   endtask

   task automatic reset_cycles(input int n, input logic fv, input logic lv);
      exp_t e;
      e = no_exp();
      e.chk_data = 1'b1;
      for (int i = 0; i < n; i++) push(1'b1, fv, lv, 1'b0, 8'($urandom), e);
   endtask

   // Reset in the middle of line 1; released with frame_valid still high.
   // Everything up to the following frame_valid low must be ignored.
   task automatic reset_mid();
      idle(2, 1'b0);
      idle(2, 1'b1);
      do_line(0, W, -1, -1, 1'b0, H);
      idle(2, 1'b1);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), no_exp());
      reset_cycles(2, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) push(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), no_exp());
      idle(2, 1'b1);
      for (int i = 0; i < W; i++) push(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), no_exp());
      idle(2, 1'b1);
      idle(1, 1'b0);
   endtask

   task automatic check(input string tag, input int cyc,
                        input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic run();
      stim_t s;
      exp_t  e;
      int    cyc;
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         e = eq.pop_front();
         @(negedge clk);
         RST         = s.rst;
         frame_valid = s.fv;
         line_valid  = s.lv;
         fifo_full   = s.ff;
         pixel_in    = s.pix;
         @(posedge clk);
         #1;
         check("w_e",       cyc, 32'(w_e),       32'(e.we));
         check("sof",       cyc, 32'(sof),       32'(e.sof));
         check("eol",       cyc, 32'(eol),       32'(e.eol));
         check("err_line",  cyc, 32'(err_line),  32'(e.el));
         check("err_frame", cyc, 32'(err_frame), 32'(e.ef));
         check("err_ovf",   cyc, 32'(err_ovf),   32'(e.eo));
         if (e.chk_data) check("data_out", cyc, data_out, e.data);
         cyc++;
      end
   endtask

   initial begin
      int tbl[6];
      int nl, bl, bw;
      int lens[4];
      int rnd[4];
      tbl = '{8, 8, 8, 4, 6, 10};
      rnd = '{-1, -1, -1, -1};
      RST = 1'b1; frame_valid = 1'b0; line_valid = 1'b0;
      pixel_in = '0; fifo_full = 1'b0;

      reset_cycles(3, 1'b0, 1'b0);
      // Nominal frame with fixed pixel values.
      frame(2, '{8, 8, 0, 0}, '{8'h00, 8'h10, 0, 0}, -1, -1, 1'b0);
      // Short first line.
      frame(2, '{6, 8, 0, 0}, '{8'h00, 8'h10, 0, 0}, -1, -1, 1'b0);
      // Second word of line 0 meets a full FIFO.
      frame(2, '{8, 8, 0, 0}, '{8'h00, 8'h10, 0, 0}, 0, 1, 1'b0);
      // Three lines in a two-line frame.
      frame(3, '{8, 8, 8, 0}, rnd, -1, -1, 1'b0);
      // Reset mid-frame, then resynchronise and capture a clean frame.
      reset_mid();
      frame(2, '{8, 8, 0, 0}, rnd, -1, -1, 1'b0);
      // line_valid and frame_valid drop together after pixel 5.
      frame(1, '{5, 0, 0, 0}, rnd, -1, -1, 1'b1);
      // Randomised frames.
      for (int f = 0; f < 8; f++) begin
         nl = $urandom_range(1, 3);
         for (int l = 0; l < 4; l++) lens[l] = tbl[$urandom_range(0, 5)];
         bl = $urandom_range(0, 3);
         bw = $urandom_range(0, 2);
         frame(nl, lens, rnd, bl, bw, ($urandom_range(0, 3) == 0));
      end
      run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_in_pack.md
VIDEO_IN_PACK -- requirements
Module: video_in_pack

Interface
REQ-001 SHALL have parameter P_WIDTH, default 640, active pixels per line; must be a multiple of P_PACK.
REQ-002 SHALL have parameter P_HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter P_PIX_W, default 8, bits per pixel.
REQ-004 SHALL have parameter P_PACK, default 4, pixels per output word; the word width is P_PIX_W*P_PACK.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port frame_valid, input, 1 bit: frame active.
REQ-008 SHALL have port line_valid, input, 1 bit: pixel valid within a line.
REQ-009 SHALL have port pixel_in, input, P_PIX_W bits: pixel sample.
REQ-010 SHALL have port fifo_full, input, 1 bit: downstream FIFO cannot accept a word.
REQ-011 SHALL have port w_e, output, 1 bit: write strobe for data_out.
REQ-012 SHALL have port data_out, output, P_PIX_W*P_PACK bits: packed pixel word.
REQ-013 SHALL have port sof, output, 1 bit: qualifies the first word of a frame.
REQ-014 SHALL have port eol, output, 1 bit: qualifies the last word of a line.
REQ-015 SHALL have port err_line, output, 1 bit: one-cycle pulse when a line length is not equal to P_WIDTH.
REQ-016 SHALL have port err_frame, output, 1 bit: one-cycle pulse when a frame line count is not equal to P_HEIGHT.
REQ-017 SHALL have port err_ovf, output, 1 bit: one-cycle pulse when a word is dropped because fifo_full is high.

Function
REQ-018 SHALL implement states SYNC, VBLANK, ACTIVE and HBLANK.
REQ-019 SYNC SHALL be left for VBLANK only when frame_valid=0 is sampled, so that capture never starts mid-frame.
REQ-020 VBLANK SHALL move to HBLANK on frame_valid=1 and SHALL clear the line counter.
REQ-021 HBLANK SHALL move to ACTIVE on frame_valid&line_valid; ACTIVE SHALL move to HBLANK on line_valid=0 with frame_valid=1; ACTIVE or HBLANK SHALL move to VBLANK on frame_valid=0.
REQ-022 Each cycle in ACTIVE with frame_valid&line_valid SHALL increment the pixel counter; a pixel SHALL be captured only if the pixel counter < P_WIDTH and the line counter < P_HEIGHT, and excess pixels or lines SHALL be silently ignored.
REQ-023 Pixel k of a group (k = pixel counter mod P_PACK) SHALL be placed at data_out bits [(P_PACK-k)*P_PIX_W-1 : (P_PACK-1-k)*P_PIX_W], so the first pixel occupies the MSBs.
REQ-024 w_e SHALL be registered and high for exactly 1 cycle, the cycle after the group's last pixel is sampled; data_out SHALL hold the complete word in that cycle.
REQ-025 sof SHALL be high with w_e for word 0 of line 0; eol SHALL be high with w_e for word P_WIDTH/P_PACK-1 of each line; sof and eol SHALL be 0 whenever w_e is 0.
REQ-026 If fifo_full=1 in the cycle w_e would assert, w_e SHALL stay 0, the word SHALL be lost, and err_ovf SHALL pulse in that cycle; no retry SHALL be made.
REQ-027 On leaving ACTIVE, if the pixel counter is not equal to P_WIDTH, err_line SHALL pulse 1 cycle later and the partial group SHALL be discarded.
REQ-028 On ACTIVE to HBLANK, the line counter SHALL increment, saturating at P_HEIGHT, and the pixel counter SHALL clear.
REQ-029 On entry to VBLANK from ACTIVE or HBLANK, if the completed-line count is not equal to P_HEIGHT, err_frame SHALL pulse 1 cycle later; the line counter SHALL clear.
REQ-030 If line_valid and frame_valid fall in the same cycle, the line check SHALL precede the frame check, both SHALL be evaluated, and both error pulses SHALL be allowed in the same cycle.
REQ-031 line_valid=1 while frame_valid=0 SHALL be ignored.
REQ-032 The pixel counter width SHALL be clog2(P_WIDTH+1) and the line counter width SHALL be clog2(P_HEIGHT+1), and neither counter SHALL wrap.

Reset
REQ-033 When RST=1 on a rising clk edge, the state SHALL become SYNC, the counters SHALL become 0, data_out SHALL become 0, and w_e, sof, eol, err_line, err_frame and err_ovf SHALL become 0.
REQ-034 Reset mid-frame SHALL discard any partial word, and no pulses SHALL occur until the next full frame boundary (frame_valid 0 then 1).

Verification (P_WIDTH=8, P_HEIGHT=2, P_PIX_W=8, P_PACK=4)
REQ-035 Nominal frame: the bench SHALL drive 2 lines of pixels 0x01..0x08 and 0x11..0x18 and check 4 w_e pulses with words 0x01020304 (sof), 0x05060708 (eol), 0x11121314, 0x15161718 (eol) and no errors.
REQ-036 Short line: the bench SHALL drive line 0 with 6 pixels and check word 0x01020304, no second word, and an err_line pulse 1 cycle after line_valid falls.
REQ-037 Backpressure: the bench SHALL hold fifo_full=1 during the second word of line 0 and check w_e=0 with an err_ovf pulse, and that the remaining 3 words are written normally.
REQ-038 Frame count: the bench SHALL send 3 lines and check an err_frame pulse, and that the third line produces no w_e.
REQ-039 Reset and sync: the bench SHALL assert RST mid-line 1, then release it with frame_valid still 1, and check no w_e until frame_valid has gone 0 and then 1, after which the next frame is captured correctly.
REQ-040 Simultaneous fall: the bench SHALL drop line_valid and frame_valid together after pixel 5 of line 0 and check err_line and err_frame pulsing in the same cycle.
